// File: rtl/vc_input_buffer.sv
// ----------------------------------------------------------------------------
// vc_input_buffer
//
// Router input-port buffer with one independent circular FIFO per virtual
// channel. At most one flit arrives per cycle and is steered to the VC named
// by in_vc. The downstream stage may pop any number of VCs in the same cycle.
// Each VC shows its head flit combinationally (show-ahead). Each successful
// pop returns a registered one-cycle credit pulse to the upstream router.
//
// Parameters
//   DATAW     : flit width in bits
//   NUM_VC    : virtual channels per input port (power of 2, >= 2)
//   BUF_DEPTH : flit slots per VC (power of 2, >= 2)
//
// Ports
//   clk          : clock; all state updates happen on the rising edge
//   reset        : asynchronous, active-low reset (0 = in reset)
//   in_valid     : a flit is presented this cycle
//   in_vc        : target VC of the incoming flit
//   in_flit      : incoming flit
//   rd_en        : per-VC pop request from the downstream stage
//   out_valid    : per-VC "head flit present" (VC non-empty)
//   out_flit     : per-VC head flit (don't-care while out_valid is 0)
//   full         : per-VC occupancy equals BUF_DEPTH
//   credit_out   : per-VC credit pulse, high for the cycle after a pop
//   overflow_err : sticky flag, set when a write to a full VC is dropped
// ----------------------------------------------------------------------------
module vc_input_buffer #(
    parameter int DATAW     = 4,
    parameter int NUM_VC    = 4,
    parameter int BUF_DEPTH = 4,
    localparam int VCW      = $clog2(NUM_VC),
    localparam int CNTW     = $clog2(BUF_DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [VCW-1:0]    in_vc,
    input  logic [DATAW-1:0]  in_flit,
    input  logic [NUM_VC-1:0] rd_en,
    output logic [NUM_VC-1:0] out_valid,
    output logic [DATAW-1:0]  out_flit [NUM_VC-1:0],
    output logic [NUM_VC-1:0] full,
    output logic [NUM_VC-1:0] credit_out,
    output logic              overflow_err
);

    localparam int              PTRW       = $clog2(BUF_DEPTH);
    localparam logic [CNTW-1:0] FULL_COUNT = CNTW'(BUF_DEPTH);

    logic [DATAW-1:0]  mem    [NUM_VC-1:0][BUF_DEPTH-1:0];
    logic [PTRW-1:0]   rd_ptr [NUM_VC-1:0];
    logic [PTRW-1:0]   wr_ptr [NUM_VC-1:0];
    logic [CNTW-1:0]   count  [NUM_VC-1:0];

    logic              wr_accept;
    logic [NUM_VC-1:0] wr_sel;
    logic [NUM_VC-1:0] pop;

    // Status flags come only from the registered counts, so a full VC
    // refuses a write even when it is popped in the same cycle.
    always_comb begin
        out_valid = '0;
        full      = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            out_valid[v] = (count[v] != '0);
            full[v]      = (count[v] == FULL_COUNT);
            out_flit[v]  = mem[v][rd_ptr[v]];
        end
    end

    // A pop on an empty VC is masked here so it moves no pointer and
    // produces no credit.
    always_comb begin
        wr_accept = in_valid && !full[in_vc];
        wr_sel    = '0;
        pop       = '0;
        for (int v = 0; v < NUM_VC; v++) begin
            wr_sel[v] = wr_accept && (in_vc == VCW'(v));
            pop[v]    = rd_en[v] && out_valid[v];
        end
    end

    // Flit storage has no reset; the counts alone decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[in_vc][wr_ptr[in_vc]] <= in_flit;
        end
    end

    // Pointers wrap naturally because BUF_DEPTH is a power of two. A write
    // and a pop on the same VC cancel out in the occupancy count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int v = 0; v < NUM_VC; v++) begin
                rd_ptr[v] <= '0;
                wr_ptr[v] <= '0;
                count[v]  <= '0;
            end
            credit_out   <= '0;
            overflow_err <= 1'b0;
        end else begin
            for (int v = 0; v < NUM_VC; v++) begin
                if (wr_sel[v]) begin
                    wr_ptr[v] <= wr_ptr[v] + PTRW'(1);
                end
                if (pop[v]) begin
                    rd_ptr[v] <= rd_ptr[v] + PTRW'(1);
                end
                case ({wr_sel[v], pop[v]})
                    2'b10:   count[v] <= count[v] + CNTW'(1);
                    2'b01:   count[v] <= count[v] - CNTW'(1);
                    default: count[v] <= count[v];
                endcase
            end
            credit_out <= pop;
            if (in_valid && !wr_accept) begin
                overflow_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vc_input_buffer.sv
// ----------------------------------------------------------------------------
// tb_vc_input_buffer
//
// Self-checking bench for vc_input_buffer (DATAW=8, NUM_VC=4, BUF_DEPTH=4).
// Each accepted write pushes its flit onto a per-VC expected queue; each pop
// compares the head flit against the front of that queue. Status outputs are
// compared against values derived from the queue sizes and a sticky overflow
// model.
// ----------------------------------------------------------------------------
module tb_vc_input_buffer;

    localparam int DATAW     = 8;
    localparam int NUM_VC    = 4;
    localparam int BUF_DEPTH = 4;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic [1:0]       in_vc;
    logic [DATAW-1:0] in_flit;
    logic [3:0]       rd_en;
    logic [3:0]       out_valid;
    logic [DATAW-1:0] out_flit [3:0];
    logic [3:0]       full;
    logic [3:0]       credit_out;
    logic             overflow_err;

    int               n_checks;
    int               n_fail;

    logic [7:0]       sbq [NUM_VC][$];
    logic             model_ovf;
    logic [3:0]       exp_credit;

    vc_input_buffer #(
        .DATAW(DATAW),
        .NUM_VC(NUM_VC),
        .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_vc(in_vc),
        .in_flit(in_flit),
        .rd_en(rd_en),
        .out_valid(out_valid),
        .out_flit(out_flit),
        .full(full),
        .credit_out(credit_out),
        .overflow_err(overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] model_valid();
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < NUM_VC; i++) r[i] = (sbq[i].size() != 0);
        return r;
    endfunction

    function automatic logic [3:0] model_full();
        logic [3:0] r;
        r = '0;
        for (int i = 0; i < NUM_VC; i++) r[i] = (sbq[i].size() == BUF_DEPTH);
        return r;
    endfunction

    // One clock cycle of stimulus; the expected state is advanced from the
    // pre-edge model contents, and outputs are sampled 1 ns after the edge.
    task automatic drive(input logic v, input int vc, input logic [7:0] f,
                         input logic [3:0] rd);
        logic [3:0] pops;
        bit         acc;
        pops     = '0;
        in_valid = v;
        in_vc    = 2'(vc);
        in_flit  = f;
        rd_en    = rd;
        acc      = v && (sbq[vc].size() < BUF_DEPTH);
        for (int i = 0; i < NUM_VC; i++) begin
            if (rd[i] && sbq[i].size() != 0) pops[i] = 1'b1;
        end
        if (v && !acc) model_ovf = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_VC; i++) begin
            if (pops[i]) void'(sbq[i].pop_front());
        end
        if (acc) sbq[vc].push_back(f);
        exp_credit = pops;
        in_valid   = 1'b0;
        rd_en      = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_VC; i++) sbq[i].delete();
        model_ovf  = 1'b0;
        exp_credit = '0;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        in_vc    = '0;
        in_flit  = '0;
        rd_en    = '0;
        model_clear();
        #1 reset = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_valid: got %b expected 0000", out_valid);
        end
        n_checks++;
        if (full !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_full: got %b expected 0000", full);
        end
        n_checks++;
        if (credit_out !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL reset_credit: got %b expected 0000", credit_out);
        end
        n_checks++;
        if (overflow_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_ovf: got %b expected 0", overflow_err);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (out_valid !== 4'b0000 || credit_out !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL post_reset: got valid %b credit %b expected 0000 0000",
                     out_valid, credit_out);
        end
    endtask

    task automatic test_basic();
        drive(1'b1, 2, 8'h11, 4'b0000);
        n_checks++;
        if (out_valid !== 4'b0100 || out_flit[2] !== sbq[2][0]) begin
            n_fail++;
            $display("[TB] FAIL basic_first: got valid %b flit %h expected 0100 %h",
                     out_valid, out_flit[2], sbq[2][0]);
        end
        drive(1'b1, 2, 8'h22, 4'b0000);
        n_checks++;
        if (out_flit[2] !== sbq[2][0]) begin
            n_fail++;
            $display("[TB] FAIL basic_head: got %h expected %h", out_flit[2], sbq[2][0]);
        end
        drive(1'b0, 0, 8'h00, 4'b0100);
        n_checks++;
        if (out_flit[2] !== sbq[2][0]) begin
            n_fail++;
            $display("[TB] FAIL basic_after_pop: got %h expected %h", out_flit[2], sbq[2][0]);
        end
        n_checks++;
        if (credit_out !== exp_credit) begin
            n_fail++;
            $display("[TB] FAIL basic_credit: got %b expected %b", credit_out, exp_credit);
        end
        drive(1'b0, 0, 8'h00, 4'b0100);
        n_checks++;
        if (credit_out !== exp_credit || out_valid !== model_valid()) begin
            n_fail++;
            $display("[TB] FAIL basic_drain: got credit %b valid %b expected %b %b",
                     credit_out, out_valid, exp_credit, model_valid());
        end
        drive(1'b0, 0, 8'h00, 4'b0000);
        n_checks++;
        if (credit_out !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL basic_credit_once: got %b expected 0000", credit_out);
        end
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i < 4; i++) drive(1'b1, 1, 8'hA0 + 8'(i), 4'b0000);
        n_checks++;
        if (full !== model_full() || overflow_err !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL full_set: got full %b ovf %b expected %b 0",
                     full, overflow_err, model_full());
        end
        drive(1'b1, 1, 8'h55, 4'b0000);
        n_checks++;
        if (overflow_err !== model_ovf || full !== model_full()) begin
            n_fail++;
            $display("[TB] FAIL overflow_set: got ovf %b full %b expected %b %b",
                     overflow_err, full, model_ovf, model_full());
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_flit[1] !== sbq[1][0] || out_flit[1] !== 8'hA0 + 8'(i)) begin
                n_fail++;
                $display("[TB] FAIL full_order: got %h expected %h", out_flit[1], 8'hA0 + 8'(i));
            end
            drive(1'b0, 0, 8'h00, 4'b0010);
        end
        n_checks++;
        if (out_valid !== model_valid() || overflow_err !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL overflow_sticky: got valid %b ovf %b expected %b 1",
                     out_valid, overflow_err, model_valid());
        end
    endtask

    task automatic test_simul_write_pop();
        drive(1'b1, 0, 8'h01, 4'b0000);
        drive(1'b1, 0, 8'h02, 4'b0000);
        n_checks++;
        if (out_flit[0] !== sbq[0][0]) begin
            n_fail++;
            $display("[TB] FAIL simul_head: got %h expected %h", out_flit[0], sbq[0][0]);
        end
        drive(1'b1, 0, 8'h03, 4'b0001);
        n_checks++;
        if (credit_out !== 4'b0001 || full !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL simul_credit: got credit %b full %b expected 0001 0000",
                     credit_out, full);
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (out_valid[0] !== 1'b1 || out_flit[0] !== sbq[0][0]) begin
                n_fail++;
                $display("[TB] FAIL simul_pop: got valid %b flit %h expected 1 %h",
                         out_valid[0], out_flit[0], sbq[0][0]);
            end
            drive(1'b0, 0, 8'h00, 4'b0001);
        end
        n_checks++;
        if (out_valid[0] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL simul_count: got valid %b expected 0", out_valid[0]);
        end
    endtask

    task automatic test_wrap_parallel();
        logic [7:0] got [$];
        logic [3:0] rd;
        for (int i = 0; i < 10; i++) begin
            rd = (sbq[3].size() >= 2) ? 4'b1000 : 4'b0000;
            if (rd[3]) begin
                n_checks++;
                if (out_flit[3] !== sbq[3][0]) begin
                    n_fail++;
                    $display("[TB] FAIL wrap_stream: got %h expected %h", out_flit[3], sbq[3][0]);
                end
                got.push_back(out_flit[3]);
            end
            drive(1'b1, 3, 8'(i), rd);
        end
        for (int k = 0; k < 8 && sbq[3].size() != 0; k++) begin
            n_checks++;
            if (out_flit[3] !== sbq[3][0]) begin
                n_fail++;
                $display("[TB] FAIL wrap_drain: got %h expected %h", out_flit[3], sbq[3][0]);
            end
            got.push_back(out_flit[3]);
            drive(1'b0, 0, 8'h00, 4'b1000);
        end
        n_checks++;
        if (got.size() != 10 || out_valid[3] !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL wrap_count: got %0d flits valid %b expected 10 0",
                     got.size(), out_valid[3]);
        end
        for (int k = 0; k < got.size(); k++) begin
            n_checks++;
            if (got[k] !== 8'(k)) begin
                n_fail++;
                $display("[TB] FAIL wrap_order: got %h expected %h", got[k], 8'(k));
            end
        end
        drive(1'b1, 0, 8'hB0, 4'b0000);
        drive(1'b1, 1, 8'hB1, 4'b0000);
        n_checks++;
        if (out_flit[0] !== 8'hB0 || out_flit[1] !== 8'hB1) begin
            n_fail++;
            $display("[TB] FAIL parallel_heads: got %h %h expected b0 b1", out_flit[0], out_flit[1]);
        end
        drive(1'b0, 0, 8'h00, 4'b0011);
        n_checks++;
        if (credit_out !== 4'b0011 || out_valid !== model_valid()) begin
            n_fail++;
            $display("[TB] FAIL parallel_credit: got credit %b valid %b expected 0011 %b",
                     credit_out, out_valid, model_valid());
        end
    endtask

    task automatic test_empty_pop();
        drive(1'b0, 0, 8'h00, 4'b1111);
        n_checks++;
        if (credit_out !== 4'b0000 || out_valid !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL empty_pop: got credit %b valid %b expected 0000 0000",
                     credit_out, out_valid);
        end
        n_checks++;
        if (overflow_err !== model_ovf) begin
            n_fail++;
            $display("[TB] FAIL empty_pop_ovf: got %b expected %b", overflow_err, model_ovf);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) drive(1'b1, 2, 8'hC0 + 8'(i), 4'b0000);
        n_checks++;
        if (out_valid !== 4'b0100) begin
            n_fail++;
            $display("[TB] FAIL mid_fill: got %b expected 0100", out_valid);
        end
        rd_en = 4'b0100;
        #2 reset = 1'b0;
        model_clear();
        #1;
        n_checks++;
        if (out_valid !== 4'b0000 || overflow_err !== 1'b0 || credit_out !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL mid_async: got valid %b ovf %b credit %b expected 0000 0 0000",
                     out_valid, overflow_err, credit_out);
        end
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (credit_out !== 4'b0000 || out_valid !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL mid_hold: got credit %b valid %b expected 0000 0000",
                     credit_out, out_valid);
        end
        @(negedge clk);
        reset = 1'b1;
        rd_en = '0;
        @(posedge clk);
        #1;
        n_checks++;
        if (credit_out !== 4'b0000 || out_valid !== 4'b0000) begin
            n_fail++;
            $display("[TB] FAIL mid_release: got credit %b valid %b expected 0000 0000",
                     credit_out, out_valid);
        end
        drive(1'b1, 2, 8'h77, 4'b0000);
        n_checks++;
        if (out_valid !== model_valid() || out_flit[2] !== sbq[2][0]) begin
            n_fail++;
            $display("[TB] FAIL mid_restart: got valid %b flit %h expected %b %h",
                     out_valid, out_flit[2], model_valid(), sbq[2][0]);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        $display("[TB] starting vc_input_buffer bench");
        test_reset();
        test_basic();
        test_full_overflow();
        test_simul_write_pop();
        test_wrap_parallel();
        test_empty_pop();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/vc_input_buffer.md
VC_INPUT_BUFFER -- requirements
Module: vc_input_buffer

Interface
REQ-001 SHALL have parameter DATAW, default 4: flit width in bits.
REQ-002 SHALL have parameter NUM_VC, default 4: virtual channels per input port (power of 2, >=2).
REQ-003 SHALL have parameter BUF_DEPTH, default 4: flit slots per VC (power of 2, >=2).
REQ-004 SHALL use derived widths VCW = $clog2(NUM_VC) and CNTW = $clog2(BUF_DEPTH+1).
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on posedge.
REQ-006 SHALL have port reset, input, 1: reset, asynchronous, active-low (0 = in reset).
REQ-007 SHALL have port in_valid, input, 1: a flit is presented this cycle.
REQ-008 SHALL have port in_vc, input, VCW: target VC of the incoming flit.
REQ-009 SHALL have port in_flit, input, DATAW: incoming flit.
REQ-010 SHALL have port rd_en, input, NUM_VC: per-VC pop request from the downstream stage.
REQ-011 SHALL have port out_valid, output, NUM_VC: per-VC head flit present (non-empty).
REQ-012 SHALL have port out_flit, output, unpacked array [NUM_VC-1:0] of DATAW: head flit per VC, directly consumable by the downstream pipeline register array input.
REQ-013 SHALL have port full, output, NUM_VC: per-VC occupancy == BUF_DEPTH.
REQ-014 SHALL have port credit_out, output, NUM_VC: one-cycle credit-return pulse per VC.
REQ-015 SHALL have port overflow_err, output, 1: sticky protocol-violation flag.

Function
REQ-016 SHALL keep one independent circular FIFO per VC: storage, read pointer, write pointer, CNTW-bit occupancy count.
REQ-017 SHALL accept a write at posedge when in_valid=1 and full[in_vc]=0, storing in_flit at that VC's write pointer.
REQ-018 SHALL evaluate full on the registered count; a write to a full VC is dropped even if the same VC pops in that cycle.
REQ-019 SHALL set overflow_err=1 on any dropped write and hold it until reset.
REQ-020 SHALL pop VC v at posedge when rd_en[v]=1 and out_valid[v]=1; rd_en[v] on an empty VC is ignored, with no state change and no credit.
REQ-021 SHALL allow pops on any number of VCs in the same cycle, plus one write.
REQ-022 SHALL, on a simultaneous accepted write and pop on the same VC, perform both and leave the count unchanged.
REQ-023 SHALL wrap pointers modulo BUF_DEPTH; count never exceeds BUF_DEPTH or underflows below 0.
REQ-024 SHALL drive out_flit[v] combinationally from the storage at read pointer v (show-ahead); out_flit[v] is don't-care while out_valid[v]=0.
REQ-025 SHALL derive out_valid[v] = (count[v] != 0) and full[v] = (count[v] == BUF_DEPTH) from registered counts.
REQ-026 SHALL have write-to-visible latency of 1 cycle: a flit written at edge N gives out_valid=1 and the flit on out_flit in the cycle after edge N.
REQ-027 SHALL register credit_out: credit_out[v]=1 for exactly the one cycle following each pop edge of VC v, else 0.
REQ-028 SHALL preserve per-VC FIFO order; VCs never interact.

Reset
REQ-029 SHALL, while reset=0, asynchronously clear all pointers, counts, credit_out and overflow_err, independent of clk.
REQ-030 SHALL hold out_valid=0, full=0, credit_out=0 and overflow_err=0 during and immediately after reset; flit storage need not be cleared.
REQ-031 SHALL, on reset mid-operation, discard all buffered flits and not emit credits for them.

Verification (DATAW=8, NUM_VC=4, BUF_DEPTH=4)
REQ-032 SHALL test reset: drive reset=0 with no clock edge -> out_valid=4'b0000, full=4'b0000, credit_out=4'b0000, overflow_err=0.
REQ-033 SHALL test basic write/read: write 0x11, then 0x22 to VC2; pulse rd_en[2] -> out_flit[2]=0x11 the cycle after the first write; 0x22 after the pop; credit_out=4'b0100 for one cycle after the pop edge.
REQ-034 SHALL test full and overflow: write 0xA0..0xA3 to VC1 -> full[1]=1; write 0x55 to VC1 -> dropped, overflow_err=1; four pops return 0xA0..0xA3 in order; overflow_err stays 1.
REQ-035 SHALL test simultaneous write and pop: VC0 holds 0x01, 0x02; write 0x03 and pop in the same cycle -> count stays 2; subsequent pops yield 0x02, 0x03.
REQ-036 SHALL test wrap-around and parallel pops: stream 0..9 through VC3 with interleaved pops -> output order 0..9; with VC0 and VC1 both non-empty, rd_en=4'b0011 -> credit_out=4'b0011 on the next cycle.
REQ-037 SHALL test empty pop and reset mid-run: rd_en=4'b1111 when all VCs are empty -> no change, credit_out=0; asserting reset with VC2 holding 3 flits -> out_valid[2]=0 immediately, no credit pulses.
